// File: rtl/iris_mem_arbiter.sv
// iris_mem_arbiter: round-robin arbiter sharing one memory port among N_CORES.
// Optional lock hint support is enabled by defining IRIS_ARB_LOCK_EN.
module iris_mem_arbiter #(
    parameter int N_CORES    = 8,
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_CORES-1:0]            req_valid,
    output logic [N_CORES-1:0]            req_ready,
    input  logic [N_CORES-1:0]            req_we,
    input  logic [N_CORES-1:0]            req_lock,
    input  logic [N_CORES*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_CORES*DATA_WIDTH-1:0] req_wdata,
    output logic [N_CORES-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          mem_ce,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          busy
);

    localparam int PW = $clog2(N_CORES);
    localparam int SW = PW + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                r_state;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         r_g;
    logic [N_CORES-1:0]    r_rsp_valid;
    logic                  r_mem_ce;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_any;
    logic [PW-1:0]         w_g;
    logic [PW-1:0]         w_g_next;
    logic [PW-1:0]         w_ptr_nxt;
    logic [N_CORES-1:0]    w_g_oh;
    logic [N_CORES-1:0]    w_r_g_oh;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Scan requesters starting at the pointer; first valid one wins.
    always_comb begin
        logic [SW-1:0] v_sum;
        v_sum = '0;
        w_any = 1'b0;
        w_g   = '0;
        for (int k = 0; k < N_CORES; k++) begin
            v_sum = {1'b0, r_ptr} + SW'(k);
            if (v_sum >= SW'(N_CORES))
                v_sum = v_sum - SW'(N_CORES);
            if (!w_any && req_valid[v_sum[PW-1:0]]) begin
                w_any = 1'b1;
                w_g   = v_sum[PW-1:0];
            end
        end
    end

    assign w_g_next = (w_g == PW'(N_CORES - 1)) ? '0 : w_g + PW'(1);
    assign w_g_oh   = {{(N_CORES-1){1'b0}}, 1'b1} << w_g;
    assign w_r_g_oh = {{(N_CORES-1){1'b0}}, 1'b1} << r_g;
    assign w_addr   = req_addr[int'(w_g)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata  = req_wdata[int'(w_g)*DATA_WIDTH +: DATA_WIDTH];

`ifdef IRIS_ARB_LOCK_EN
    logic [1:0] r_lock_cnt;
    logic [1:0] w_lock_base;
    logic       w_hold;

    // A lock run continues only while the same core keeps winning.
    assign w_lock_base = (r_g == w_g) ? r_lock_cnt : 2'd0;
    assign w_hold      = req_lock[w_g] && (w_lock_base != 2'd3);
    assign w_ptr_nxt   = w_hold ? w_g : w_g_next;

    // Count consecutive locked grants; the fourth one releases the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= 2'd0;
        end else if (r_state == IDLE) begin
            if (w_any && w_hold)
                r_lock_cnt <= w_lock_base + 2'd1;
            else
                r_lock_cnt <= 2'd0;
        end
    end
`else
    logic w_lock_unused;
    assign w_lock_unused = ^req_lock;
    assign w_ptr_nxt     = w_g_next;
`endif

    // Arbitration FSM with registered memory and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_g         <= '0;
            r_rsp_valid <= '0;
            r_mem_ce    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rsp_valid <= '0;
                    if (w_any) begin
                        r_g         <= w_g;
                        r_ptr       <= w_ptr_nxt;
                        r_mem_ce    <= 1'b1;
                        r_mem_we    <= req_we[w_g];
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_mem_ce    <= 1'b0;
                    r_rsp_valid <= w_r_g_oh;
                    r_state     <= RESP;
                end
                RESP: begin
                    r_rsp_valid <= '0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_mem_ce    <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == IDLE && w_any) ? w_g_oh : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = (r_state == RESP && !r_mem_we) ? mem_rdata : '0;
    assign mem_ce    = r_mem_ce;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_iris_mem_arbiter.sv
// tb_iris_mem_arbiter: scoreboard bench for iris_mem_arbiter.
// Expected grants are queued by the test; a monitor checks memory and responses.
module tb_iris_mem_arbiter;

    localparam int N  = 8;
    localparam int DW = 24;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst_n;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_ce;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic            busy;

    iris_mem_arbiter #(.N_CORES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        logic [23:0] data;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [23:0] wdata;
        int          cyc;
    } mem_t;

    int   exp_gnt[$];
    rsp_t exp_rsp[$];
    mem_t exp_mem[$];

    bit [23:0] mem[int];
    bit [23:0] ref_mem[int];

    logic [N-1:0] tb_we;
    logic [N-1:0] tb_lock;
    logic [15:0]  tb_addr[N];
    logic [23:0]  tb_wdata[N];
    int           issued[N];
    int           served[N];
    logic [N-1:0] acc_r = '0;

    int cyc = 0;
    int last_acc = -10;
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always_comb begin
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]             = (issued[i] != served[i]);
            req_addr[i*AW +: AW]     = tb_addr[i];
            req_wdata[i*DW +: DW]    = tb_wdata[i];
        end
    end
    assign req_we   = tb_we;
    assign req_lock = tb_lock;

    // Shared memory model with one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_ce) begin
            if (mem_we)
                mem[int'(mem_addr)] = mem_wdata;
            else
                mem_rdata <= mem[int'(mem_addr)];
        end
    end

    // Retire accepted requests just after the accepting edge.
    always @(posedge clk) begin
        #1;
        if (rst_n)
            for (int i = 0; i < N; i++)
                if (acc_r[i]) served[i]++;
    end

    // Monitor: grants, memory strobes and responses.
    always @(negedge clk) begin
        logic [N-1:0] acc;
        int           g;
        mem_t         m;
        rsp_t         r;
        acc   = req_valid & req_ready;
        acc_r = rst_n ? acc : '0;
        if (rst_n) begin
            if (acc != 0) begin
                if (exp_gnt.size() == 0) begin
                    check("gnt_extra", 32'(acc), 32'h0);
                end else begin
                    g = exp_gnt.pop_front();
                    check("gnt", 32'(req_ready), 32'(1) << g);
                    check("gnt_gap", 32'(cyc - last_acc >= 3), 32'h1);
                    last_acc = cyc;
                    m.we = tb_we[g];
                    m.addr = tb_addr[g];
                    m.wdata = tb_wdata[g];
                    m.cyc = cyc;
                    exp_mem.push_back(m);
                    r.core = g;
                    r.cyc = cyc;
                    r.data = tb_we[g] ? 24'h0 : ref_mem[int'(tb_addr[g])];
                    if (tb_we[g]) ref_mem[int'(tb_addr[g])] = tb_wdata[g];
                    exp_rsp.push_back(r);
                end
            end
            if (mem_ce) begin
                if (exp_mem.size() == 0) begin
                    check("mem_extra", 32'(mem_ce), 32'h0);
                end else begin
                    m = exp_mem.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(m.addr));
                    check("mem_we", 32'(mem_we), 32'(m.we));
                    if (m.we) check("mem_wdata", 32'(mem_wdata), 32'(m.wdata));
                    check("mem_cyc", 32'(cyc), 32'(m.cyc + 1));
                    check("mem_busy", 32'(busy), 32'h1);
                end
            end
            if (rsp_valid != 0) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_extra", 32'(rsp_valid), 32'h0);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_core", 32'(rsp_valid), 32'(1) << r.core);
                    check("rsp_data", 32'(rsp_rdata), 32'(r.data));
                    check("rsp_cyc", 32'(cyc), 32'(r.cyc + 2));
                end
            end
        end
    end

    task automatic issue(input int i, input int n);
        issued[i] += n;
    endtask

    task automatic preload(input logic [15:0] a, input logic [23:0] d);
        mem[int'(a)] = d;
        ref_mem[int'(a)] = d;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (req_valid == 0 && !busy && exp_gnt.size() == 0 &&
                exp_rsp.size() == 0)
                return;
        end
        check("timeout", 32'(int'(req_valid != 0) + int'(busy) +
              exp_gnt.size() + exp_rsp.size()), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_acc = -10;
    endtask

    initial begin
        rst_n   = 1'b0;
        tb_we   = '0;
        tb_lock = '0;
        for (int i = 0; i < N; i++) begin
            issued[i]   = 0;
            served[i]   = 0;
            tb_addr[i]  = 16'h0200 + 16'(i);
            tb_wdata[i] = '0;
            preload(16'h0200 + 16'(i), 24'h5A0000 + 24'(i));
        end

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp", 32'(rsp_valid), 32'h0);
        check("rst_rdata", 32'(rsp_rdata), 32'h0);
        check("rst_ce", 32'(mem_ce), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read by core 3
        tb_addr[3] = 16'h0010;
        preload(16'h0010, 24'hABCDEF);
        exp_gnt.push_back(3);
        issue(3, 1);
        wait_idle();

        // Write then read by core 0
        tb_addr[0]  = 16'h00FF;
        tb_wdata[0] = 24'h123456;
        tb_we[0]    = 1'b1;
        exp_gnt.push_back(0);
        issue(0, 1);
        wait_idle();
        tb_we[0] = 1'b0;
        exp_gnt.push_back(0);
        issue(0, 1);
        wait_idle();

        // All cores request from reset
        do_reset();
        for (int i = 0; i < N; i++) tb_addr[i] = 16'h0200 + 16'(i);
        for (int i = 0; i < N; i++) exp_gnt.push_back(i);
        exp_gnt.push_back(0);
        issue(0, 2);
        for (int i = 1; i < N; i++) issue(i, 1);
        wait_idle();

        // Sparse contention with pointer at 5
        exp_gnt.push_back(4);
        issue(4, 1);
        wait_idle();
        exp_gnt.push_back(6);
        exp_gnt.push_back(2);
        issue(2, 1);
        issue(6, 1);
        wait_idle();

        // Reset during ACCESS
        exp_gnt.push_back(4);
        issue(4, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_ce) break;
        end
        check("abort_ce", 32'(mem_ce), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ce0", 32'(mem_ce), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_rsp", 32'(rsp_valid), 32'h0);
        check("abort_addr", 32'(mem_addr), 32'h0);
        exp_rsp.delete();
        exp_mem.delete();
        last_acc = -10;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_gnt.push_back(0);
        exp_gnt.push_back(3);
        issue(0, 1);
        issue(3, 1);
        wait_idle();

        // Lock hint from core 1 against core 2
        tb_lock[1] = 1'b1;
`ifdef IRIS_ARB_LOCK_EN
        exp_gnt = '{1, 1, 1, 1, 2, 1, 2};
`else
        exp_gnt = '{1, 2, 1, 2, 1, 1, 1};
`endif
        issue(1, 5);
        issue(2, 2);
        wait_idle();
        tb_lock[1] = 1'b0;

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iris_mem_arbiter.md
# iris_mem_arbiter

Round-robin arbiter that shares a single 24-bit memory port between the N_CORES shader cores of the iris GPU. Each core issues single-beat read/write requests over a valid/ready handshake. The arbiter serialises them onto one memory instance with 1-cycle read latency and routes a response pulse back to the requesting core. It sits between the core array and a shared scratch memory, replacing per-core memory wiring.

## Interface
Parameters:
- N_CORES, 8, number of requesters (2..16)
- DATA_WIDTH, 24, data word width
- ADDR_WIDTH, 16, memory word address width

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_CORES  per-core request valid
- req_ready  out  N_CORES  per-core accept; one-hot or zero
- req_we  in  N_CORES  per-core write enable (1 = write)
- req_lock  in  N_CORES  per-core lock hint (see Configuration)
- req_addr  in  N_CORES*ADDR_WIDTH  flattened addresses; core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  N_CORES*DATA_WIDTH  flattened write data; core i at [i*DATA_WIDTH +: DATA_WIDTH]
- rsp_valid  out  N_CORES  one-cycle response pulse to the granted core
- rsp_rdata  out  DATA_WIDTH  read data, shared; valid only with rsp_valid
- mem_ce  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by mem_ce
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_ce with mem_we=0
- busy  out  1  high in ACCESS or RESP

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state: IDLE.
- IDLE, no req_valid: stay in IDLE.
- IDLE, any req_valid: select winner g, assert req_ready[g], register we/addr/wdata and g, go to ACCESS.
- ACCESS: drive mem_ce=1 with the registered fields. Go to RESP.
- RESP: rsp_valid[g]=1. rsp_rdata = mem_rdata for reads, 0 for writes. Go to IDLE.
- Writes also get an rsp_valid pulse, which acts as a completion ack.
- Round-robin: pointer p (width clog2(N_CORES), reset 0). Scan cores p, p+1, …, wrapping at N_CORES; the first core with req_valid wins. After the grant, p = (g+1) mod N_CORES.
- Non-winning requesters hold req_valid and their fields stable until accepted. The arbiter never drops a request.
- The arbiter never grants a core that has req_valid low.
- A core may present a new request in the same cycle its rsp_valid is high. That request is arbitrated in the following IDLE cycle.
- Async reset mid-transaction: the FSM goes to IDLE immediately, the in-flight access is abandoned, no rsp_valid is issued, and p returns to 0.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- req_ready is combinational from req_valid and state, asserted only in IDLE. The handshake completes when req_valid&req_ready are both high at a rising edge.
- Accept at cycle T, mem_ce at T+1, rsp_valid at T+2, next accept no earlier than T+3.
- Throughput is one transaction per 3 cycles.
- Worst-case wait for a continuously requesting core, without lock: (N_CORES-1) transactions.
- mem_* outputs are registered. They hold their last values when mem_ce=0.

## Configuration
- Macro: IRIS_ARB_LOCK_EN.
- Defined:
  - If req_lock[g] is high at accept, p is not advanced, so g wins the next arbitration if it is still requesting.
  - The lock is capped at 4 consecutive grants by a 2-bit counter. After the 4th grant, p advances normally and the counter clears.
  - The counter also clears when g releases lock or stops requesting.
- Undefined: req_lock is ignored, and arbitration is pure round-robin.

## Test plan
- Single read: core 3 reads addr 0x0010, memory returns 0xABCDEF → req_ready[3] at T, mem_ce/mem_addr=0x0010 at T+1, rsp_valid[3] with rsp_rdata=0xABCDEF at T+2.
- Write then read: core 0 writes 0x123456 to 0x00FF, then reads 0x00FF → mem_we=1 on the first access, write ack at T+2, read returns 0x123456.
- All 8 cores request continuously from reset → grant order 0,1,2,…,7,0, each grant 3 cycles apart, no core granted twice before all others.
- Sparse contention: p=5, only cores 2 and 6 request → core 6 is granted, then core 2.
- Reset mid-operation: assert rst_n=0 during ACCESS → all outputs 0 immediately, no rsp_valid; after release, core 0 has priority.
- Lock (IRIS_ARB_LOCK_EN): core 1 holds lock and requests while core 2 also requests → 4 consecutive grants to core 1, then core 2. With the macro undefined, grants alternate 1,2.
